// File: rtl/ula_seq_pkg.sv
// Shared definitions for the ULA operand sequencer: FSM state encodings
// (also shown on LEDG through oStep) and the ULA opcode values.
package ula_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_SHR = 2'b10;
  localparam logic [1:0] SEL_SHL = 2'b11;

endpackage

// File: rtl/ula_op_sequencer_if.sv
// Board-side bundle of the ULA operand sequencer: the step key, the switch bank,
// the ULA result coming back and the registered operands/result going out.
// The master modport is the sequencer; the slave modport is the board/ULA side.
// Optional flag outputs exist only when ULA_SEQ_FLAGS_EN is defined.
interface ula_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             iKEY_N;
  logic [WIDTH-1:0] iDATA;
  logic [WIDTH-1:0] iRES;
  logic [WIDTH-1:0] oA;
  logic [WIDTH-1:0] oB;
  logic [1:0]       oSel;
  logic [WIDTH-1:0] oResult;
  logic             oValid;
  logic [2:0]       oStep;
`ifdef ULA_SEQ_FLAGS_EN
  logic             oZero;
  logic             oCarry;
`endif

  modport master (
    input  iKEY_N, iDATA, iRES,
`ifdef ULA_SEQ_FLAGS_EN
    output oZero, oCarry,
`endif
    output oA, oB, oSel, oResult, oValid, oStep
  );

  modport slave (
    output iKEY_N, iDATA, iRES,
`ifdef ULA_SEQ_FLAGS_EN
    input  oZero, oCarry,
`endif
    input  oA, oB, oSel, oResult, oValid, oStep
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level debouncer and a
// one-cycle pulse on each debounced released->pressed transition.
// The key is active low; reset leaves the debounced level at "released".
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iKEY_N,
  output logic oPress
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          press_r;

  // Bring the asynchronous key into the clock domain (idles high = released).
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], iKEY_N};
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples;
  // a sample equal to the current level restarts the count.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      level_r <= 1'b1;
      cnt_r   <= {CW{1'b0}};
      press_r <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync_r[1] == level_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= {CW{1'b0}};
        level_r <= sync_r[1];
        press_r <= ~sync_r[1];
      end else begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign oPress = press_r;
endmodule

// File: rtl/ula_op_sequencer.sv
// Sequential operand/opcode loader for the 4-bit ULA. One debounced key steps
// A -> B -> Sel -> EXEC -> SHOW; the ULA itself sits outside and feeds iRES back.
// Define ULA_SEQ_FLAGS_EN to add registered zero/carry flags alongside oResult.
module ula_op_sequencer
  import ula_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  ula_op_sequencer_if.master bus
);
  logic             press_s;
  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [1:0]       sel_r;
  logic [WIDTH-1:0] result_r;
  logic             valid_r;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iKEY_N(bus.iKEY_N),
    .oPress(press_s)
  );

`ifdef ULA_SEQ_FLAGS_EN
  logic [WIDTH:0] sum_s;
  logic           zero_s;
  logic           carry_s;
  logic           zero_r;
  logic           carry_r;

  // Flags from the operands the ULA is currently seeing: carry-out on add,
  // borrow on sub, nothing for shifts.
  always_comb begin
    sum_s  = {1'b0, a_r} + {1'b0, b_r};
    zero_s = (bus.iRES == {WIDTH{1'b0}});
    case (sel_r)
      SEL_ADD: carry_s = sum_s[WIDTH];
      SEL_SUB: carry_s = (a_r < b_r);
      default: carry_s = 1'b0;
    endcase
  end
`endif

  // Step FSM and operand/result registers; the result is captured in the single
  // EXEC cycle, when oA/oB/oSel have been stable for at least one cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r  <= S_A;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      sel_r    <= SEL_ADD;
      result_r <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
      zero_r   <= 1'b0;
      carry_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_A: begin
          if (press_s) begin
            a_r     <= bus.iDATA;
            valid_r <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
`endif
            state_r <= S_B;
          end
        end
        S_B: begin
          if (press_s) begin
            b_r     <= bus.iDATA;
            state_r <= S_OP;
          end
        end
        S_OP: begin
          if (press_s) begin
            sel_r   <= bus.iDATA[1:0];
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_r <= bus.iRES;
          valid_r  <= 1'b1;
`ifdef ULA_SEQ_FLAGS_EN
          zero_r   <= zero_s;
          carry_r  <= carry_s;
`endif
          state_r  <= S_SHOW;
        end
        S_SHOW: begin
          // A press while showing a result starts the next entry with A.
          if (press_s) begin
            a_r     <= bus.iDATA;
            valid_r <= 1'b0;
`ifdef ULA_SEQ_FLAGS_EN
            zero_r  <= 1'b0;
            carry_r <= 1'b0;
`endif
            state_r <= S_B;
          end
        end
        default: begin
          state_r <= S_A;
        end
      endcase
    end
  end

  assign bus.oA      = a_r;
  assign bus.oB      = b_r;
  assign bus.oSel    = sel_r;
  assign bus.oResult = result_r;
  assign bus.oValid  = valid_r;
  assign bus.oStep   = state_r;
`ifdef ULA_SEQ_FLAGS_EN
  assign bus.oZero   = zero_r;
  assign bus.oCarry  = carry_r;
`endif
endmodule
